// File: rtl/carry_select_sequencer.sv
// Multi-cycle carry-select adder: one SLICE-bit slice per cycle, LSB first.
// Both slice sums are formed each cycle and the registered carry selects one.
module carry_select_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("WIDTH must be a positive multiple of SLICE");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_k, b_k;
  logic [SLICE:0]   s0, s1, chosen;
  logic             msb_cin;
  logic             last;

  always_comb begin
    a_k    = a_q[int'(idx_q)*SLICE +: SLICE];
    b_k    = b_q[int'(idx_q)*SLICE +: SLICE];
    s0     = {1'b0, a_k} + {1'b0, b_k};
    s1     = s0 + {{SLICE{1'b0}}, 1'b1};
    chosen = carry_q ? s1 : s0;
    // carry into the slice MSB recovered from its sum bit
    msb_cin = chosen[SLICE-1] ^ a_k[SLICE-1] ^ b_k[SLICE-1];
    last    = (idx_q == IW'(NSLICE - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = chosen[SLICE-1:0];
        carry_d = chosen[SLICE];
        if (last) begin
          cout_d  = chosen[SLICE];
          ovf_d   = msb_cin ^ chosen[SLICE];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_select_sequencer.sv
// Bench for carry_select_sequencer: arithmetic reference model plus
// literal cases for latency, backpressure, reset abort and streaming.
module tb_carry_select_sequencer;

  localparam int W = 16;
  localparam int NS = 4;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] a = 0;
  logic [W-1:0] b = 0;
  logic         cin = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad = 0;

  carry_select_sequencer #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model phases: 0 waiting, 1 computing, 2 holding result
  int           m_ph = 0;
  int           m_left = 0;
  logic [W:0]   m_full;
  logic [W-1:0] m_sum = 0;
  logic         m_cout = 0;
  logic         m_ovf = 0;
  logic         m_as, m_bs;
  int           cyc = 0;
  int           acc_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0;
      m_sum = 0;
      m_cout = 0;
      m_ovf = 0;
    end else begin
      cyc++;
      if (m_ph == 0) begin
        if (in_valid) begin
          m_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          m_as = a[W-1];
          m_bs = b[W-1];
          m_sum = 0;
          m_left = NS;
          m_ph = 1;
          acc_q.push_back(cyc);
        end
      end else if (m_ph == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_sum = m_full[W-1:0];
          m_cout = m_full[W];
          m_ovf = (m_as == m_bs) && (m_full[W-1] != m_as);
          m_ph = 2;
        end
      end else if (out_ready) begin
        m_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !rst && m_ph == 0);
    chk("busy", busy, m_ph == 1);
    chk("out_valid", out_valid, m_ph == 2);
    if (m_ph != 1) chk("sum", sum, m_sum);
    if (m_ph == 2) begin
      chk("cout", cout, m_cout);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic add_lit(input string nm, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tc,
                         input logic [W-1:0] es, input logic ec,
                         input logic eo, input int hold);
    int n;
    logic [W-1:0] s_held;
    @(negedge clk); #1;
    in_valid = 1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    in_valid = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_lat"}, n, NS);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_model"}, {m_cout, m_ovf, m_sum}, {ec, eo, es});
    s_held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk({nm, "_hold_rdy"}, in_ready, 0);
      chk({nm, "_hold_ov"}, out_valid, 1);
      chk({nm, "_hold_sum"}, sum, s_held);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({nm, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {in_ready, busy, out_valid, sum, cout, ovf}, 0);
    @(negedge clk); #1;
    rst = 0;
    #1 chk("rst_release_rdy", in_ready, 1);

    add_lit("t1", 16'h1234, 16'h1111, 0, 16'h2345, 0, 0, 0);
    add_lit("t2", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
    add_lit("t3a", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
    add_lit("t3b", 16'h0000, 16'h0000, 1, 16'h0001, 0, 0, 0);
    add_lit("t4", 16'h8000, 16'h8000, 1, 16'h0001, 1, 1, 5);

    // abort in the middle of the walk
    @(negedge clk); #1;
    in_valid = 1; a = 16'hABCD; b = 16'h1357; cin = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 chk("abort", {out_valid, busy, sum}, 0);
    @(negedge clk); #1;
    rst = 0;
    add_lit("t5", 16'hABCD, 16'h1357, 1, 16'hBF25, 0, 0, 0);

    // streaming with both handshakes held high
    acc_q.delete();
    @(negedge clk); #1;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk); #1;
    end
    in_valid = 0;
    repeat (8) @(negedge clk);
    #1 out_ready = 0;
    chk("b2b_count", acc_q.size() >= 3, 1);
    for (int i = 1; i < 3 && i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], NS + 2);

    // random traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      in_valid = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
      case ($urandom % 4)
        0: begin a = 16'hFFFF; b = W'($urandom % 2); end
        1: begin a = 16'h7FFF; b = W'($urandom % 3); end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      cin = 1'($urandom);
    end
    in_valid = 0;
    out_ready = 1;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
